// File: rtl/ising_pkg.sv
// Shared types, default parameters and the weight clamp for the Ising run controller.
package ising_pkg;

    localparam int unsigned DEF_N           = 8;
    localparam int unsigned DEF_NUM_WEIGHTS = 15;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_RST_CYCLES  = 16;
    localparam int unsigned WDATA_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RST  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } run_state_e;

    // Saturate a weight to the highest representable level (num_weights-1).
    function automatic logic [WDATA_W-1:0] clamp_weight(
        input logic [WDATA_W-1:0] w,
        input int unsigned        num_weights
    );
        logic [WDATA_W-1:0] max_w;
        max_w = WDATA_W'(num_weights - 1);
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/ising_cmd_fifo.sv
// First-word-fall-through command buffer; DEPTH must be a power of two >= 2.
module ising_cmd_fifo #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr_q];
    assign count   = count_q;

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ising_run_ctrl.sv
// Ising array run controller: buffers weight writes, loads them, resets the
// oscillators, runs for a programmed cycle count and signals completion.
// Build option: define ISING_WEIGHT_CLAMP_EN to saturate written weights.
module ising_run_ctrl #(
    parameter int unsigned N           = ising_pkg::DEF_N,
    parameter int unsigned NUM_WEIGHTS = ising_pkg::DEF_NUM_WEIGHTS,
    parameter int unsigned FIFO_DEPTH  = ising_pkg::DEF_FIFO_DEPTH,
    parameter int unsigned RST_CYCLES  = ising_pkg::DEF_RST_CYCLES
) (
    input  logic                    clk,
    input  logic                    axi_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [$clog2(N)-1:0]    cmd_row,
    input  logic [$clog2(N)-1:0]    cmd_col,
    input  logic                    cmd_vh,
    input  logic [31:0]             cmd_wdata,
    input  logic                    start,
    input  logic [31:0]             run_cycles,
    output logic                    wready,
    output logic [$clog2(N)-1:0]    wr_row,
    output logic [$clog2(N)-1:0]    wr_col,
    output logic                    vh,
    output logic [31:0]             wdata,
    output logic                    ising_rstn,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             cycle_count
);

    import ising_pkg::*;

    localparam int unsigned RW      = $clog2(N);
    localparam int unsigned ENTRY_W = 2 * RW + 1 + WDATA_W;
    localparam int unsigned FCW     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RCW     = $clog2(RST_CYCLES + 1);
`ifdef ISING_WEIGHT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    run_state_e        state_q, state_d;
    logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       run_len_q, run_len_d;
    logic              rstn_q, rstn_d;

    logic              push;
    logic              pop;
    logic [ENTRY_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FCW-1:0]    fifo_count;
    logic [RW-1:0]     head_row;
    logic [RW-1:0]     head_col;
    logic              head_vh;
    logic [WDATA_W-1:0] head_wdata;

    // Commands are taken only while idle or loading; full blocks push even if a pop is due.
    assign cmd_ready = ~axi_rst & ~fifo_full & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign push      = cmd_valid & cmd_ready;

    ising_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (axi_rst),
        .push  (push),
        .wdata ({cmd_row, cmd_col, cmd_vh, cmd_wdata}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign {head_row, head_col, head_vh, head_wdata} = head;

    // Array write port is driven straight from the FIFO head while loading.
    assign wready      = pop;
    assign wr_row      = head_row;
    assign wr_col      = head_col;
    assign vh          = head_vh;
    assign wdata       = CLAMP_EN ? clamp_weight(head_wdata, NUM_WEIGHTS) : head_wdata;
    assign ising_rstn  = rstn_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign cycle_count = cycle_count_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            run_len_q     <= '0;
            rstn_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            run_len_q     <= run_len_d;
            rstn_q        <= rstn_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        run_len_d     = run_len_q;
        rstn_d        = rstn_q;
        pop           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    run_len_d     = run_cycles;
                    cycle_count_d = '0;
                    rst_cnt_d     = '0;
                    if (!fifo_empty || push) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_RST;
                        rstn_d  = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                pop = ~fifo_empty;
                // Leave once this cycle's pop drains the buffer and nothing new arrives.
                if (!push && (fifo_count == FCW'(pop))) begin
                    state_d = ST_RST;
                    rstn_d  = 1'b0;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                    rstn_d  = 1'b1;
                    state_d = (run_len_q == '0) ? ST_DONE : ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end
            ST_RUN: begin
                if (cycle_count_q == run_len_q - 32'd1) begin
                    state_d = ST_DONE;
                end else begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
